// File: rtl/aligner_out_buffer_pkg.sv
// Shared definitions for the Aligner output buffer: flag bit positions, widths
// and the tkeep mask helper.
package aligner_out_buffer_pkg;

   localparam int ALIGN_FLAG_VALID = 2;
   localparam int ALIGN_FLAG_STALL = 1;
   localparam int ALIGN_FLAG_TLAST = 0;

   localparam int ALIGNED_WIDTH = 256;
   // in_last_bytes is 6 bits wide, so no mask ever needs more than 64 bits
   localparam int KEEP_MAX_W = 64;

   function automatic int entry_width(input int data_w);
      return data_w + data_w / 8 + 1;
   endfunction

   localparam int ALIGNED_ENTRY_WIDTH = entry_width(ALIGNED_WIDTH);

   // Zero or out-of-range byte counts mean a full word
   function automatic logic [KEEP_MAX_W-1:0] keep_mask(input logic [5:0] n_bytes,
                                                       input int keep_w);
      logic [KEEP_MAX_W-1:0] m;
      int lim;
      lim = (n_bytes == 6'd0 || int'(n_bytes) > keep_w) ? keep_w : int'(n_bytes);
      m = '0;
      for (int i = 0; i < KEEP_MAX_W; i++) begin
         if (i < lim) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/aligner_out_buffer_if.sv
// AXI-Stream style output bundle of the Aligner output buffer.
interface aligner_out_buffer_if
   import aligner_out_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = ALIGNED_WIDTH
);
   logic [DATA_WIDTH-1:0]   m_tdata;
   logic [DATA_WIDTH/8-1:0] m_tkeep;
   logic                    m_tlast;
   logic                    m_tvalid;
   logic                    m_tready;

   modport master (output m_tdata, m_tkeep, m_tlast, m_tvalid, input m_tready);
   modport slave  (input m_tdata, m_tkeep, m_tlast, m_tvalid, output m_tready);
endinterface

// File: rtl/aligner_fifo_core.sv
// Synchronous FIFO with a first-word-fall-through output register; count covers
// the output register plus storage, and read/write may coincide at any level.
module aligner_fifo_core
   import aligner_out_buffer_pkg::*;
#(
   parameter int WIDTH = ALIGNED_ENTRY_WIDTH,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_accept,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] stor_cnt;
   logic             rd_fire;
   logic             load_out;
   logic             pop_mem;
   logic             bypass;
   logic             push_mem;

   // A write into empty storage while the output register is free goes
   // straight to the output register, which keeps ordering intact
   assign rd_fire   = rd_valid & rd_ready;
   assign wr_accept = wr_en & ((count < CNT_W'(DEPTH)) | rd_fire);
   assign stor_cnt  = count - CNT_W'(rd_valid);
   assign load_out  = ~rd_valid | rd_fire;
   assign pop_mem   = load_out & (stor_cnt != '0);
   assign bypass    = wr_accept & load_out & (stor_cnt == '0);
   assign push_mem  = wr_accept & ~bypass;

   always_ff @(posedge clk) begin
      if (push_mem) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (push_mem) wr_ptr <= wr_ptr + AW'(1);
         if (pop_mem)  rd_ptr <= rd_ptr + AW'(1);
         if (load_out) begin
            if (pop_mem) begin
               rd_data  <= mem[rd_ptr];
               rd_valid <= 1'b1;
            end else if (bypass) begin
               rd_data  <= wr_data;
               rd_valid <= 1'b1;
            end else begin
               rd_valid <= 1'b0;
            end
         end
         count <= count + CNT_W'(wr_accept) - CNT_W'(rd_fire);
      end
   end

endmodule

// File: rtl/aligner_out_buffer.sv
// Buffers Aligner output words and replays them as an AXI-Stream master, with
// tkeep generation, almost_full back-pressure, packet word counts and overflow.
module aligner_out_buffer
   import aligner_out_buffer_pkg::*;
#(
   parameter int DATA_WIDTH   = ALIGNED_WIDTH,
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 3,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [2:0]            in_flags,
   input  logic [5:0]            in_last_bytes,
   output logic                  almost_full,
   aligner_out_buffer_if.master  m_axis,
   output logic [CNT_WIDTH-1:0]  pkt_words,
   output logic                  pkt_done,
   output logic                  overflow
);
   localparam int KEEP_W   = DATA_WIDTH / 8;
   localparam int ENTRY_W  = entry_width(DATA_WIDTH);
   localparam int FIFO_CW  = $clog2(DEPTH) + 1;

   logic [KEEP_MAX_W-1:0] mask_full;
   logic [KEEP_W-1:0]     in_keep;
   logic [ENTRY_W-1:0]    wr_entry;
   logic [ENTRY_W-1:0]    rd_entry;
   logic                  wr_accept;
   logic [FIFO_CW-1:0]    fifo_count;
   logic [CNT_WIDTH-1:0]  word_cnt;
   logic [CNT_WIDTH-1:0]  cnt_inc;
   logic                  unused_bits;

   assign mask_full   = keep_mask(in_last_bytes, KEEP_W);
   assign in_keep     = in_flags[ALIGN_FLAG_TLAST] ? mask_full[KEEP_W-1:0] : '1;
   assign wr_entry    = {in_flags[ALIGN_FLAG_TLAST], in_keep, in_data};
   assign unused_bits = in_flags[ALIGN_FLAG_STALL] ^ (^mask_full);

   aligner_fifo_core #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH),
      .CNT_W (FIFO_CW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (in_flags[ALIGN_FLAG_VALID]),
      .wr_data   (wr_entry),
      .wr_accept (wr_accept),
      .rd_ready  (m_axis.m_tready),
      .rd_valid  (m_axis.m_tvalid),
      .rd_data   (rd_entry),
      .count     (fifo_count)
   );

   assign m_axis.m_tdata = rd_entry[DATA_WIDTH-1:0];
   assign m_axis.m_tkeep = rd_entry[DATA_WIDTH +: KEEP_W];
   assign m_axis.m_tlast = rd_entry[ENTRY_W-1];

   assign almost_full = (fifo_count >= FIFO_CW'(DEPTH - AFULL_MARGIN));
   assign cnt_inc     = (word_cnt == '1) ? word_cnt : word_cnt + CNT_WIDTH'(1);

   // Only words the FIFO actually took count toward a packet
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_cnt  <= '0;
         pkt_words <= '0;
         pkt_done  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         if (wr_accept) begin
            if (in_flags[ALIGN_FLAG_TLAST]) begin
               pkt_words <= cnt_inc;
               pkt_done  <= 1'b1;
               word_cnt  <= '0;
            end else begin
               word_cnt <= cnt_inc;
            end
         end
         if (in_flags[ALIGN_FLAG_VALID] && !wr_accept) overflow <= 1'b1;
      end
   end

endmodule
